mips_debug_ctrl: RTL and testbench

//  Run/step/breakpoint controller for the single-cycle MIPS core. Gates the core's

---
 rtl/mips_debug_ctrl_pkg.sv | 32 +++
 rtl/mips_debug_ctrl_trace_fifo.sv | 62 ++++++
 rtl/mips_debug_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_ctrl_pkg.sv
// Shared encodings for the MIPS debug controller: FSM state, host command opcodes,
// halt causes, and a constant-foldable clog2 used for port widths.
package mips_debug_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_HALT  = 2'b00,
    OP_RUN   = 2'b01,
    OP_STEP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    HC_NONE      = 2'b00,
    HC_CMD       = 2'b01,
    HC_BP        = 2'b10,
    HC_STEP_DONE = 2'b11
  } halt_cause_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_debug_ctrl_trace_fifo.sv
// Show-ahead circular trace buffer. When full, a push without a pop either evicts
// the oldest entry (WRAP!=0) or is discarded (WRAP==0); both set the sticky overflow.
module mips_trace_fifo
  import mips_debug_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  parameter int WRAP  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          rd_data,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, do_pop, full_push, do_write, drop_oldest;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign do_pop      = pop & ~empty;
  // A simultaneous pop frees a slot, so only a pop-less push into a full buffer loses data.
  assign full_push   = push & full & ~do_pop;
  assign do_write    = push & (~full_push | (WRAP != 0));
  assign drop_oldest = full_push & (WRAP != 0);
  assign rd_data     = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop | drop_oldest) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_write & ~drop_oldest) - CW'(do_pop);
      if (full_push) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; validity is tracked by count, so stale words are never observed.
  always_ff @(posedge clock) begin
    if (do_write && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Run/step/breakpoint controller for the single-cycle MIPS core: gates the core clock
// enable, counts executed cycles and records a {pc, instr} trace per executed cycle.
module mips_debug_ctrl
  import mips_debug_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_BP      = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int TRACE_WRAP  = 1,
  parameter int CYC_W       = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd_op,
  input  logic [CYC_W-1:0]            cmd_arg,
  output logic                        cmd_ready,
  input  logic [NUM_BP-1:0]           bp_en,
  input  logic [NUM_BP*DATA_W-1:0]    bp_addr,
  input  logic [DATA_W-1:0]           cpu_pc,
  input  logic [DATA_W-1:0]           cpu_instr,
  output logic                        cpu_clk_en,
  output logic [1:0]                  state,
  output logic [1:0]                  halt_cause,
  output logic [2:0]                  bp_idx,
  output logic [CYC_W-1:0]            cycle_count,
  input  logic                        tr_rd_en,
  output logic [2*DATA_W-1:0]         tr_rd_data,
  output logic [clog2(TRACE_DEPTH):0] tr_count,
  output logic                        tr_empty,
  output logic                        tr_overflow
);

  state_e             state_q, state_d;
  halt_cause_e        cause_q, cause_d;
  logic [2:0]         bp_idx_q, bp_idx_d;
  logic [CYC_W-1:0]   step_q, step_d;
  logic [CYC_W-1:0]   cycle_q;
  logic               first_q, first_d;
  logic               clk_en, clear, bp_hit, halt_req, fire;
  logic [2:0]         hit_idx;
  cmd_op_e            op;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_HALTED) | (op == OP_HALT);
  assign fire      = cmd_valid & cmd_ready;
  assign halt_req  = fire & (op == OP_HALT);

  // Scan from the top so the lowest matching comparator is the one left standing.
  always_comb begin
    bp_hit  = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (cpu_pc == bp_addr[i*DATA_W +: DATA_W])) begin
        bp_hit  = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    bp_idx_d = bp_idx_q;
    step_d   = step_q;
    first_d  = first_q;
    clk_en   = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      ST_HALTED: begin
        if (fire) begin
          unique case (op)
            OP_RUN: begin
              state_d = ST_RUN;
              first_d = 1'b1;
            end
            OP_STEP: begin
              state_d = ST_STEP;
              step_d  = (cmd_arg == '0) ? CYC_W'(1) : cmd_arg;
            end
            OP_CLEAR: begin
              clear   = 1'b1;
              cause_d = HC_NONE;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // first_q lets RUN leave a PC it was just halted on.
        first_d = 1'b0;
        if (halt_req) begin
          state_d = ST_HALTED;
          cause_d = HC_CMD;
        end else if (bp_hit && !first_q) begin
          state_d  = ST_HALTED;
          cause_d  = HC_BP;
          bp_idx_d = hit_idx;
        end else begin
          clk_en = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_d = ST_HALTED;
          cause_d = HC_CMD;
        end else begin
          clk_en = 1'b1;
          step_d = step_q - 1'b1;
          if (step_q == CYC_W'(1)) begin
            state_d = ST_HALTED;
            cause_d = HC_STEP_DONE;
          end
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HALTED;
      cause_q  <= HC_NONE;
      bp_idx_q <= '0;
      step_q   <= '0;
      first_q  <= 1'b0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      bp_idx_q <= bp_idx_d;
      step_q   <= step_d;
      first_q  <= first_d;
      if (clear) cycle_q <= '0;
      else if (clk_en && !(&cycle_q)) cycle_q <= cycle_q + 1'b1;
    end
  end

  mips_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .W     (2 * DATA_W),
    .WRAP  (TRACE_WRAP)
  ) u_trace (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (clk_en),
    .push_data ({cpu_pc, cpu_instr}),
    .pop       (tr_rd_en),
    .rd_data   (tr_rd_data),
    .count     (tr_count),
    .overflow  (tr_overflow)
  );

  assign cpu_clk_en  = clk_en;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign bp_idx      = bp_idx_q;
  assign cycle_count = cycle_q;
  assign tr_empty    = (tr_count == '0);

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: a queue-based reference model checked every
// cycle, table-driven breakpoint/step vectors, directed corner cases and random commands.
module tb_mips_debug_ctrl;

  localparam int DW = 32;
  localparam int NB = 2;
  localparam int DEPTH = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic [1:0]      cmd_op;
  logic [31:0]     cmd_arg;
  logic [NB-1:0]   bp_en;
  logic [NB*DW-1:0] bp_addr;
  logic [31:0]     cpu_pc;
  logic [31:0]     cpu_instr;
  logic            tr_rd_en;
  logic            pc_set;
  logic [31:0]     pc_set_val;

  logic            cmd_ready_w, clk_en_w, empty_w, ovf_w;
  logic [1:0]      state_w, cause_w;
  logic [2:0]      bp_idx_w;
  logic [31:0]     cyc_w;
  logic [63:0]     rd_w;
  logic [4:0]      cnt_w;
  logic            cmd_ready_n, clk_en_n, empty_n, ovf_n;
  logic [1:0]      state_n, cause_n;
  logic [2:0]      bp_idx_n;
  logic [31:0]     cyc_n;
  logic [63:0]     rd_n;
  logic [4:0]      cnt_n;

  mips_debug_ctrl #(.DATA_W(DW), .NUM_BP(NB), .TRACE_DEPTH(DEPTH), .TRACE_WRAP(1), .CYC_W(32)) dut_w (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready_w), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .cpu_clk_en(clk_en_w), .state(state_w), .halt_cause(cause_w), .bp_idx(bp_idx_w),
    .cycle_count(cyc_w), .tr_rd_en(tr_rd_en), .tr_rd_data(rd_w), .tr_count(cnt_w),
    .tr_empty(empty_w), .tr_overflow(ovf_w));

  mips_debug_ctrl #(.DATA_W(DW), .NUM_BP(NB), .TRACE_DEPTH(DEPTH), .TRACE_WRAP(0), .CYC_W(32)) dut_nw (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready_n), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .cpu_clk_en(clk_en_n), .state(state_n), .halt_cause(cause_n), .bp_idx(bp_idx_n),
    .cycle_count(cyc_n), .tr_rd_en(tr_rd_en), .tr_rd_data(rd_n), .tr_count(cnt_n),
    .tr_empty(empty_n), .tr_overflow(ovf_n));

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h8C00_A5A5;
  endfunction

  // Stand-in core: PC advances by one instruction on every enabled cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) cpu_pc <= '0;
    else if (pc_set) cpu_pc <= pc_set_val;
    else if (clk_en_w) cpu_pc <= cpu_pc + 32'd4;
  end
  assign cpu_instr = instr_of(cpu_pc);

  int pulses = 0;
  always @(posedge clock) if (!reset && clk_en_w) pulses <= pulses + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain counters plus two trace queues (wrap and no-wrap).
  int          m_state, m_cause, m_bpidx;
  bit          m_first;
  logic [31:0] m_step, m_cyc;
  logic [63:0] q_w[$], q_nw[$];
  bit          m_ovf_w, m_ovf_nw;
  int          n_state, n_cause, n_bpidx;
  bit          n_first;
  logic [31:0] n_step;
  bit          m_en, m_ready, m_clear, cap_rd;
  logic [63:0] cap_ent;

  task automatic model_reset();
    m_state = 0; m_cause = 0; m_bpidx = 0; m_first = 0; m_step = 0; m_cyc = 0;
    q_w.delete(); q_nw.delete(); m_ovf_w = 0; m_ovf_nw = 0;
  endtask

  task automatic model_comb();
    bit fire, hit;
    int hidx;
    m_ready = (m_state == 0) || (cmd_op == 2'd0);
    fire = cmd_valid && m_ready;
    hit = 0; hidx = 0;
    for (int i = 0; i < NB; i++)
      if (!hit && bp_en[i] && cpu_pc == bp_addr[i*DW +: DW]) begin hit = 1; hidx = i; end
    n_state = m_state; n_cause = m_cause; n_bpidx = m_bpidx; n_first = m_first; n_step = m_step;
    m_en = 0; m_clear = 0;
    if (m_state == 0) begin
      if (fire && cmd_op == 2'd1) begin n_state = 1; n_first = 1; end
      if (fire && cmd_op == 2'd2) begin n_state = 2; n_step = (cmd_arg == 0) ? 32'd1 : cmd_arg; end
      if (fire && cmd_op == 2'd3) begin m_clear = 1; n_cause = 0; end
    end else if (fire && cmd_op == 2'd0) begin
      n_state = 0; n_cause = 1;
      if (m_state == 1) n_first = 0;
    end else if (m_state == 1) begin
      n_first = 0;
      if (hit && !m_first) begin n_state = 0; n_cause = 2; n_bpidx = hidx; end
      else m_en = 1;
    end else begin
      m_en = 1;
      n_step = m_step - 1;
      if (m_step == 1) begin n_state = 0; n_cause = 3; end
    end
  endtask

  task automatic model_seq();
    m_state = n_state; m_cause = n_cause; m_bpidx = n_bpidx; m_first = n_first; m_step = n_step;
    if (m_clear) begin
      m_cyc = 0; q_w.delete(); q_nw.delete(); m_ovf_w = 0; m_ovf_nw = 0;
    end else begin
      if (m_en && m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (cap_rd && q_w.size() > 0) void'(q_w.pop_front());
      if (cap_rd && q_nw.size() > 0) void'(q_nw.pop_front());
      if (m_en) begin
        if (q_w.size() == DEPTH) begin void'(q_w.pop_front()); m_ovf_w = 1; end
        q_w.push_back(cap_ent);
        if (q_nw.size() == DEPTH) m_ovf_nw = 1;
        else q_nw.push_back(cap_ent);
      end
    end
  endtask

  // One clock: compare against the model mid-cycle, advance both across the edge.
  task automatic cycle();
    @(negedge clock);
    model_comb();
    check("cmd_ready", cmd_ready_w, m_ready);
    check("cmd_ready_nw", cmd_ready_n, m_ready);
    check("cpu_clk_en", clk_en_w, m_en);
    check("cpu_clk_en_nw", clk_en_n, m_en);
    check("state", state_w, m_state);
    check("halt_cause", cause_w, m_cause);
    check("bp_idx", bp_idx_w, m_bpidx);
    check("cycle_count", cyc_w, m_cyc);
    check("tr_count", cnt_w, q_w.size());
    check("tr_count_nw", cnt_n, q_nw.size());
    check("tr_empty", empty_w, q_w.size() == 0);
    check("tr_overflow", ovf_w, m_ovf_w);
    check("tr_overflow_nw", ovf_n, m_ovf_nw);
    if (q_w.size() > 0) check("tr_head", rd_w, q_w[0]);
    if (q_nw.size() > 0) check("tr_head_nw", rd_n, q_nw[0]);
    cap_ent = {cpu_pc, cpu_instr};
    cap_rd = tr_rd_en;
    @(posedge clock);
    model_seq();
    #1;
    cmd_valid = 0; tr_rd_en = 0; pc_set = 0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1; cmd_op = op; cmd_arg = arg;
    cycle();
  endtask

  task automatic clear_at(input logic [31:0] pc);
    pc_set = 1; pc_set_val = pc;
    cmd(2'd3, 0);
  endtask

  task automatic wait_halt(input int max, input string name);
    int n = 0;
    while (state_w != 2'd0 && n < max) begin cycle(); n++; end
    check(name, state_w, 2'd0);
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [31:0] a0, a1;
    logic [2:0]  exp_idx;
    logic [31:0] exp_cyc;
  } bp_vec_t;

  typedef struct {
    logic [31:0] arg;
    int          exp_pulses;
  } step_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bp_vec_t   bpv[4];
    step_vec_t stv[4];
    int        p0;
    bpv[0] = '{2'b01, 32'h0C, 32'h20, 3'd0, 32'd3};
    bpv[1] = '{2'b11, 32'h10, 32'h10, 3'd0, 32'd4};
    bpv[2] = '{2'b11, 32'h14, 32'h08, 3'd1, 32'd2};
    bpv[3] = '{2'b10, 32'h0C, 32'h08, 3'd1, 32'd2};
    stv[0] = '{32'd5, 5};
    stv[1] = '{32'd0, 1};
    stv[2] = '{32'd1, 1};
    stv[3] = '{32'd3, 3};

    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_arg = 0; bp_en = 0; bp_addr = 0;
    tr_rd_en = 0; pc_set = 0; pc_set_val = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;

    check("rst_state", state_w, 2'd0);
    check("rst_clk_en", clk_en_w, 1'b0);
    check("rst_empty", empty_w, 1'b1);
    check("rst_cycle_count", cyc_w, 32'd0);

    // 1: free run for 10 cycles
    cmd(2'd1, 0);
    repeat (10) cycle();
    check("run10_cycle_count", cyc_w, 32'd10);
    check("run10_tr_count", cnt_w, 5'd10);
    cmd(2'd0, 0);

    // 2: breakpoint table, then resume from the breakpointed PC
    foreach (bpv[k]) begin
      bp_en = bpv[k].en;
      bp_addr = {bpv[k].a1, bpv[k].a0};
      clear_at(32'h0);
      cmd(2'd1, 0);
      wait_halt(50, "bp_halted");
      check("bp_cause", cause_w, 2'd2);
      check("bp_idx", bp_idx_w, bpv[k].exp_idx);
      check("bp_cycles", cyc_w, bpv[k].exp_cyc);
      check("bp_pc", cpu_pc, bpv[k].exp_cyc * 4);
      cmd(2'd1, 0);
      repeat (2) cycle();
      cmd(2'd0, 0);
      check("bp_resume_cycles", cyc_w, bpv[k].exp_cyc + 2);
      check("bp_resume_cause", cause_w, 2'd1);
    end

    // 3: step table
    foreach (stv[k]) begin
      clear_at(32'h100);
      p0 = pulses;
      cmd(2'd2, stv[k].arg);
      wait_halt(300, "step_halted");
      check("step_pulses", pulses - p0, stv[k].exp_pulses);
      check("step_cause", cause_w, 2'd3);
    end

    // 4: 20 executed cycles into a 16-deep trace, wrap vs drop
    clear_at(32'h0);
    cmd(2'd2, 32'd20);
    wait_halt(100, "fill_halted");
    check("fill_count_w", cnt_w, 5'd16);
    check("fill_count_nw", cnt_n, 5'd16);
    check("fill_ovf_w", ovf_w, 1'b1);
    check("fill_ovf_nw", ovf_n, 1'b1);
    check("fill_head_w", rd_w[63:32], 32'h10);
    check("fill_head_nw", rd_n[63:32], 32'h00);
    repeat (15) begin tr_rd_en = 1; cycle(); end
    check("tail_w", rd_w, {32'h4C, instr_of(32'h4C)});
    check("tail_nw", rd_n, {32'h3C, instr_of(32'h3C)});
    check("tail_count", cnt_w, 5'd1);

    // 5: HALT during a long STEP, and RUN refused while running
    clear_at(32'h0);
    cmd(2'd2, 32'd100);
    repeat (7) cycle();
    cmd(2'd0, 0);
    check("halt_step_cycles", cyc_w, 32'd7);
    check("halt_step_cause", cause_w, 2'd1);
    cmd(2'd1, 0);
    cmd_valid = 1; cmd_op = 2'd1; #1;
    check("run_in_run_ready", cmd_ready_w, 1'b0);
    cycle();
    check("run_in_run_state", state_w, 2'd1);
    cmd(2'd0, 0);

    // 6: asynchronous reset mid-RUN, then CLEAR
    cmd(2'd1, 0);
    repeat (3) cycle();
    @(negedge clock);
    check("pre_reset_clk_en", clk_en_w, 1'b1);
    #2 reset = 1;
    #1;
    check("async_clk_en", clk_en_w, 1'b0);
    check("async_state", state_w, 2'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 0;
    check("post_rst_cycles", cyc_w, 32'd0);
    check("post_rst_count", cnt_w, 5'd0);
    check("post_rst_cause", cause_w, 2'd0);
    check("post_rst_bp_idx", bp_idx_w, 3'd0);
    check("post_rst_ovf", ovf_w, 1'b0);
    cmd(2'd2, 32'd20);
    wait_halt(100, "refill_halted");
    check("refill_ovf", ovf_w, 1'b1);
    cmd(2'd3, 0);
    check("clear_cycles", cyc_w, 32'd0);
    check("clear_count", cnt_w, 5'd0);
    check("clear_ovf_w", ovf_w, 1'b0);
    check("clear_ovf_nw", ovf_n, 1'b0);
    check("clear_cause", cause_w, 2'd0);

    // Random commands, breakpoints, pops and PC jumps against the model
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_arg = $urandom_range(0, 6);
      tr_rd_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bp_en = 2'($urandom_range(0, 3));
        bp_addr = {32'($urandom_range(0, 15) * 4), 32'($urandom_range(0, 15) * 4)};
      end
      if ($urandom_range(0, 19) == 0) begin
        pc_set = 1; pc_set_val = 32'($urandom_range(0, 15) * 4);
      end
      cycle();
    end
    cmd(2'd0, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
